rob_circular: RTL and testbench
===============================

# rob_circular

Parametrised circular reorder buffer for the Tomasulo datapath. Allocates entries in program order at dispatch, captures results broadcast on the CDB by tag, and retires the head entry in order to the register file. It also exposes two operand-lookup ports for rename/RS dispatch and flags branch mispredictions at commit. It replaces the fixed single-entry reorder buffer.

## Interface
Parameters:
- DATA_WIDTH, 16, width of result value
- DEPTH, 8, number of entries; must be a power of two, at least 2
- TAG_WIDTH, $clog2(DEPTH), ROB tag width (tag = entry index)
- OP_WIDTH, 4, opcode field width
- REG_WIDTH, 3, architectural register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries
- alloc  in  1  allocate an entry at the tail this cycle
- alloc_op  in  OP_WIDTH  opcode of allocated instruction
- alloc_dest  in  REG_WIDTH  destination register
- alloc_is_br  in  1  entry is a conditional branch
- alloc_predict  in  1  predicted direction (1 = taken)
- alloc_ready  in  1  value is already known at dispatch
- alloc_value  in  DATA_WIDTH  value used when alloc_ready = 1
- alloc_tag  out  TAG_WIDTH  tag the entry receives (current tail)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  producing entry
- cdb_data  in  DATA_WIDTH  result value
- cdb_taken  in  1  resolved branch direction
- rd_tag0 / rd_tag1  in  TAG_WIDTH  operand lookup tags
- rd_ready0 / rd_ready1  out  1  looked-up entry is busy and has its value
- rd_value0 / rd_value1  out  DATA_WIDTH  looked-up value
- commit_valid  out  1  head entry is busy and ready
- commit_op / commit_dest / commit_value  out  head entry fields
- commit_mispredict  out  1  head is a branch with predict != taken
- commit_ack  in  1  consumer retires head this cycle

## Operation
- Per-entry state: busy, ready, op, dest, is_br, predict, taken, value. Head and tail pointers are TAG_WIDTH wide and wrap naturally. count is TAG_WIDTH+1 wide.
- Allocation: an allocation is accepted iff alloc & !full (evaluated on pre-edge state). On acceptance, entry[tail] is written with busy=1, ready=alloc_ready, value=alloc_value, taken=0. tail increments. An alloc while full is ignored, and no state changes.
- CDB capture: if cdb_valid, entry[cdb_tag] is busy and not ready, it sets ready=1, value=cdb_data, taken=cdb_taken. A broadcast to a non-busy or already-ready entry is ignored.
- Commit: commit_valid = busy[head] & ready[head]. commit_* fields are driven from entry[head] combinationally. commit_mispredict = commit_valid & is_br & (predict != taken). A retirement occurs iff commit_ack & commit_valid; it clears busy[head] and increments head. commit_ack with commit_valid=0 is ignored.
- count update: count += accepted_alloc − retirement. Simultaneous alloc and commit while full: alloc is refused (full was set at the start of the cycle) and the commit proceeds.
- Lookup: rd_readyN = busy & ready of entry[rd_tagN], or CDB bypass. The bypass applies when cdb_valid, cdb_tag == rd_tagN and the entry is busy. Under bypass, rd_readyN = 1 and rd_valueN = cdb_data.
- Flush: has priority over alloc, CDB and commit in the same cycle. It clears all busy bits and sets head = tail = count = 0. The external controller asserts flush in the cycle after it observes commit_mispredict with commit_ack.

## Timing
- Reset (async) gives: all busy/ready = 0, head = tail = count = 0. Outputs after reset: empty=1, full=0, alloc_tag=0, commit_valid=0, commit_mispredict=0, rd_ready*=0. Value outputs are 0 after reset.
- alloc_tag, full, empty, commit_* and rd_* are combinational from registered state plus the CDB (rd_* only).
- An entry allocated in cycle N is visible at the head and to lookup in cycle N+1. A CDB write in cycle N makes commit_valid rise in cycle N+1. Minimum dispatch-to-retire time is 1 cycle with alloc_ready=1.
- Sustained throughput: 1 alloc + 1 retire per cycle when neither full nor empty.

## Test plan
- Reset, then 8 allocs with no commits (DEPTH=8) -> alloc_tag goes 0..7, full=1 after the 8th. A 9th alloc is ignored and tail stays 0.
- Alloc tags 0,1,2 not ready; CDB writes tag2=0x00AA, then tag0=0x0011 -> commit_valid only after tag0 is written. Retire order is 0x0011, then tag1 stalls head until CDB writes tag1=0x0022, then tag2 0x00AA.
- Lookup rd_tag0=1 in the same cycle CDB writes tag1=0x1234 -> rd_ready0=1, rd_value0=0x1234 that cycle (bypass).
- Branch allocated with predict=1, CDB cdb_taken=0, commit_ack -> commit_mispredict=1. Then flush gives empty=1, alloc_tag=0.
- Full ROB plus alloc plus commit_ack in the same cycle -> one retirement, alloc refused, count=7. Wrap test: 20 alloc/commit pairs cycle tail through 7->0 with correct values.
- Assert rst mid-stream with 5 busy entries -> all outputs immediately at reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/rob_circular.sv
// Circular reorder buffer: in-order allocate at tail, out-of-order result capture
// from the CDB by tag, in-order retirement from head, plus two operand-lookup ports.
module rob_circular #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = $clog2(DEPTH),
    parameter int OP_WIDTH   = 4,
    parameter int REG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  alloc,
    input  logic [OP_WIDTH-1:0]   alloc_op,
    input  logic [REG_WIDTH-1:0]  alloc_dest,
    input  logic                  alloc_is_br,
    input  logic                  alloc_predict,
    input  logic                  alloc_ready,
    input  logic [DATA_WIDTH-1:0] alloc_value,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic                  full,
    output logic                  empty,

    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    input  logic                  cdb_taken,

    input  logic [TAG_WIDTH-1:0]  rd_tag0,
    input  logic [TAG_WIDTH-1:0]  rd_tag1,
    output logic                  rd_ready0,
    output logic                  rd_ready1,
    output logic [DATA_WIDTH-1:0] rd_value0,
    output logic [DATA_WIDTH-1:0] rd_value1,

    output logic                  commit_valid,
    output logic [OP_WIDTH-1:0]   commit_op,
    output logic [REG_WIDTH-1:0]  commit_dest,
    output logic [DATA_WIDTH-1:0] commit_value,
    output logic                  commit_mispredict,
    input  logic                  commit_ack
);

    localparam int CNT_W = TAG_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Control state (reset)
    logic [DEPTH-1:0]     busy_q, busy_d;
    logic [DEPTH-1:0]     ready_q, ready_d;
    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Payload state (no reset; only meaningful while busy)
    logic [DEPTH-1:0]      is_br_q, is_br_d;
    logic [DEPTH-1:0]      predict_q, predict_d;
    logic [DEPTH-1:0]      taken_q, taken_d;
    logic [OP_WIDTH-1:0]   op_q    [DEPTH];
    logic [OP_WIDTH-1:0]   op_d    [DEPTH];
    logic [REG_WIDTH-1:0]  dest_q  [DEPTH];
    logic [REG_WIDTH-1:0]  dest_d  [DEPTH];
    logic [DATA_WIDTH-1:0] value_q [DEPTH];
    logic [DATA_WIDTH-1:0] value_d [DEPTH];

    logic alloc_fire;
    logic retire;
    logic cdb_hit;
    logic head_busy;
    logic bypass0;
    logic bypass1;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign alloc_tag = tail_q;

    // Head view; payload fields are masked while the head slot is idle so the
    // outputs read as zero out of reset rather than stale/unknown data.
    always_comb begin
        head_busy         = busy_q[head_q];
        commit_valid      = head_busy & ready_q[head_q];
        commit_op         = head_busy ? op_q[head_q]    : '0;
        commit_dest       = head_busy ? dest_q[head_q]  : '0;
        commit_value      = head_busy ? value_q[head_q] : '0;
        commit_mispredict = commit_valid & is_br_q[head_q]
                            & (predict_q[head_q] != taken_q[head_q]);
    end

    // Operand lookup with same-cycle CDB bypass
    always_comb begin
        bypass0   = cdb_valid & (cdb_tag == rd_tag0) & busy_q[rd_tag0];
        bypass1   = cdb_valid & (cdb_tag == rd_tag1) & busy_q[rd_tag1];
        rd_ready0 = bypass0 | (busy_q[rd_tag0] & ready_q[rd_tag0]);
        rd_ready1 = bypass1 | (busy_q[rd_tag1] & ready_q[rd_tag1]);
        rd_value0 = '0;
        rd_value1 = '0;
        if (bypass0) begin
            rd_value0 = cdb_data;
        end else if (rd_ready0) begin
            rd_value0 = value_q[rd_tag0];
        end
        if (bypass1) begin
            rd_value1 = cdb_data;
        end else if (rd_ready1) begin
            rd_value1 = value_q[rd_tag1];
        end
    end

    always_comb begin
        alloc_fire = alloc & ~full;
        retire     = commit_ack & commit_valid;
        cdb_hit    = cdb_valid & busy_q[cdb_tag] & ~ready_q[cdb_tag];

        busy_d    = busy_q;
        ready_d   = ready_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        is_br_d   = is_br_q;
        predict_d = predict_q;
        taken_d   = taken_q;
        op_d      = op_q;
        dest_d    = dest_q;
        value_d   = value_q;

        // A CDB hit can never target the tail (idle) or a retiring head (ready),
        // so the three updates below touch disjoint entries.
        if (cdb_hit) begin
            ready_d[cdb_tag] = 1'b1;
            value_d[cdb_tag] = cdb_data;
            taken_d[cdb_tag] = cdb_taken;
        end

        if (retire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + TAG_WIDTH'(1);
        end

        if (alloc_fire) begin
            busy_d[tail_q]    = 1'b1;
            ready_d[tail_q]   = alloc_ready;
            value_d[tail_q]   = alloc_value;
            taken_d[tail_q]   = 1'b0;
            op_d[tail_q]      = alloc_op;
            dest_d[tail_q]    = alloc_dest;
            is_br_d[tail_q]   = alloc_is_br;
            predict_d[tail_q] = alloc_predict;
            tail_d            = tail_q + TAG_WIDTH'(1);
        end

        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        is_br_q   <= is_br_d;
        predict_q <= predict_d;
        taken_q   <= taken_d;
        op_q      <= op_d;
        dest_q    <= dest_d;
        value_q   <= value_d;
    end

endmodule

// File: tb/tb_rob_circular.sv
// Bench for rob_circular: directed scenarios plus random traffic, checked against
// a program-order queue model of the reorder buffer.
module tb_rob_circular;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TW    = 3;
    localparam int OW    = 4;
    localparam int RW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          alloc = 1'b0;
    logic [OW-1:0] alloc_op = '0;
    logic [RW-1:0] alloc_dest = '0;
    logic          alloc_is_br = 1'b0;
    logic          alloc_predict = 1'b0;
    logic          alloc_ready = 1'b0;
    logic [DW-1:0] alloc_value = '0;
    logic [TW-1:0] alloc_tag;
    logic          full;
    logic          empty;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          cdb_taken = 1'b0;
    logic [TW-1:0] rd_tag0 = '0;
    logic [TW-1:0] rd_tag1 = '0;
    logic          rd_ready0;
    logic          rd_ready1;
    logic [DW-1:0] rd_value0;
    logic [DW-1:0] rd_value1;
    logic          commit_valid;
    logic [OW-1:0] commit_op;
    logic [RW-1:0] commit_dest;
    logic [DW-1:0] commit_value;
    logic          commit_mispredict;
    logic          commit_ack = 1'b0;

    rob_circular #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW), .OP_WIDTH(OW), .REG_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc(alloc), .alloc_op(alloc_op), .alloc_dest(alloc_dest),
        .alloc_is_br(alloc_is_br), .alloc_predict(alloc_predict),
        .alloc_ready(alloc_ready), .alloc_value(alloc_value),
        .alloc_tag(alloc_tag), .full(full), .empty(empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
        .rd_tag0(rd_tag0), .rd_tag1(rd_tag1),
        .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
        .rd_value0(rd_value0), .rd_value1(rd_value1),
        .commit_valid(commit_valid), .commit_op(commit_op), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_mispredict(commit_mispredict),
        .commit_ack(commit_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [OW-1:0] op;
        logic [RW-1:0] dest;
        logic          is_br;
        logic          predict;
        logic          taken;
        logic          ready;
        logic [DW-1:0] value;
    } ent_t;

    ent_t rob[$];
    int   ntag = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < rob.size(); i++)
            if (rob[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic lookup_exp(input int tag, output logic r, output logic [DW-1:0] v);
        int k;
        k = find(tag);
        r = 1'b0;
        v = '0;
        if (k >= 0) begin
            if (cdb_valid && int'(cdb_tag) == tag) begin
                r = 1'b1;
                v = cdb_data;
            end else if (rob[k].ready) begin
                r = 1'b1;
                v = rob[k].value;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic          cv;
        logic          er;
        logic [DW-1:0] ev;
        cv = 1'b0;
        if (rob.size() > 0) cv = rob[0].ready;
        chk({tag, ".empty"}, empty, rob.size() == 0);
        chk({tag, ".full"}, full, rob.size() == DEPTH);
        chk({tag, ".alloc_tag"}, alloc_tag, ntag);
        chk({tag, ".commit_valid"}, commit_valid, cv);
        if (cv) begin
            chk({tag, ".commit_mispredict"}, commit_mispredict,
                rob[0].is_br && (rob[0].predict != rob[0].taken));
            chk({tag, ".commit_op"}, commit_op, rob[0].op);
            chk({tag, ".commit_dest"}, commit_dest, rob[0].dest);
            chk({tag, ".commit_value"}, commit_value, rob[0].value);
        end else begin
            chk({tag, ".commit_mispredict"}, commit_mispredict, 1'b0);
        end
        lookup_exp(int'(rd_tag0), er, ev);
        chk({tag, ".rd_ready0"}, rd_ready0, er);
        if (er) chk({tag, ".rd_value0"}, rd_value0, ev);
        lookup_exp(int'(rd_tag1), er, ev);
        chk({tag, ".rd_ready1"}, rd_ready1, er);
        if (er) chk({tag, ".rd_value1"}, rd_value1, ev);
    endtask

    task automatic model_update();
        int   k;
        logic cv;
        logic room;
        ent_t e;
        if (flush) begin
            rob.delete();
            ntag = 0;
            return;
        end
        cv   = (rob.size() > 0) && rob[0].ready;
        room = rob.size() < DEPTH;
        if (cdb_valid) begin
            k = find(int'(cdb_tag));
            if (k >= 0 && !rob[k].ready) begin
                rob[k].ready = 1'b1;
                rob[k].value = cdb_data;
                rob[k].taken = cdb_taken;
            end
        end
        if (commit_ack && cv) void'(rob.pop_front());
        if (alloc && room) begin
            e.tag = ntag; e.op = alloc_op; e.dest = alloc_dest;
            e.is_br = alloc_is_br; e.predict = alloc_predict; e.taken = 1'b0;
            e.ready = alloc_ready; e.value = alloc_value;
            rob.push_back(e);
            ntag = (ntag + 1) % DEPTH;
        end
    endtask

    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc = 0; alloc_ready = 0; alloc_is_br = 0; alloc_predict = 0;
        cdb_valid = 0; commit_ack = 0;
    endtask

    task automatic set_alloc(input logic rdy, input logic [DW-1:0] val, input logic br,
                             input logic pred);
        alloc = 1; alloc_ready = rdy; alloc_value = val; alloc_is_br = br;
        alloc_predict = pred;
        alloc_op = OW'($urandom_range(0, 15));
        alloc_dest = RW'($urandom_range(0, 7));
    endtask

    task automatic set_cdb(input int t, input logic [DW-1:0] d, input logic tk);
        cdb_valid = 1; cdb_tag = TW'(t); cdb_data = d; cdb_taken = tk;
    endtask

    initial begin
        int t;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.empty", empty, 1'b1);
        chk("reset.full", full, 1'b0);
        chk("reset.alloc_tag", alloc_tag, 0);
        chk("reset.commit_valid", commit_valid, 1'b0);
        chk("reset.commit_mispredict", commit_mispredict, 1'b0);
        chk("reset.commit_value", commit_value, 0);
        chk("reset.rd_ready0", rd_ready0, 1'b0);
        chk("reset.rd_ready1", rd_ready1, 1'b0);
        chk("reset.rd_value0", rd_value0, 0);
        rst = 0;
        @(posedge clk);
        #1;

        // Fill to full, then a refused 9th alloc
        for (int i = 0; i < 9; i++) begin
            set_alloc(1'b0, 16'h0, 1'b0, 1'b0);
            step("fill");
        end
        idle();
        step("fill_done");
        chk("fill.tail_wrapped", alloc_tag, 0);
        chk("fill.full_held", full, 1'b1);
        flush = 1; step("flush1"); idle();

        // Out-of-order completion, in-order retirement
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b0, 16'h0, 1'b0, 1'b0);
            step("ooo_alloc");
        end
        idle(); commit_ack = 1;
        set_cdb(2, 16'h00AA, 1'b0); step("ooo_cdb2");
        chk("ooo.no_commit_yet", commit_valid, 1'b0);
        set_cdb(0, 16'h0011, 1'b0); step("ooo_cdb0");
        cdb_valid = 0;
        chk("ooo.retire0", commit_value, 16'h0011);
        step("ooo_ret0");
        step("ooo_stall");
        set_cdb(1, 16'h0022, 1'b0); step("ooo_cdb1");
        cdb_valid = 0;
        step("ooo_ret1");
        chk("ooo.retire2", commit_value, 16'h00AA);
        step("ooo_ret2");
        idle(); step("ooo_end");

        // Lookup bypass in the cycle of the CDB write
        set_alloc(1'b0, 16'h0, 1'b0, 1'b0); t = ntag; step("byp_a0");
        set_alloc(1'b0, 16'h0, 1'b0, 1'b0); step("byp_a1");
        idle();
        rd_tag0 = TW'(t + 1 - 1 + 1) ; rd_tag1 = TW'(t);
        set_cdb((t + 1) % DEPTH, 16'h1234, 1'b0);
        #1;
        chk("bypass.rd_ready0", rd_ready0, 1'b1);
        chk("bypass.rd_value0", rd_value0, 16'h1234);
        chk("bypass.rd_ready1", rd_ready1, 1'b0);
        step("byp_cdb");
        idle(); flush = 1; step("flush2"); idle();

        // Branch misprediction then flush
        set_alloc(1'b0, 16'h0, 1'b1, 1'b1); step("br_alloc");
        idle(); set_cdb(0, 16'h0055, 1'b0); step("br_cdb");
        idle(); commit_ack = 1;
        #1;
        chk("br.commit_mispredict", commit_mispredict, 1'b1);
        step("br_commit");
        idle(); flush = 1; step("br_flush");
        idle(); step("br_after");
        chk("br.empty_after_flush", empty, 1'b1);

        // Full plus alloc plus commit in one cycle
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
            step("full_fill");
        end
        set_alloc(1'b1, 16'hBEEF, 1'b0, 1'b0); commit_ack = 1; step("full_both");
        idle();
        chk("full_both.not_full", full, 1'b0);
        step("full_after");
        flush = 1; step("flush3"); idle();

        // Wrap: alloc/commit pairs running the tail past DEPTH-1
        for (int i = 0; i < 20; i++) begin
            set_alloc(1'b1, DW'($urandom_range(0, 65535)), 1'b0, 1'b0);
            commit_ack = 1;
            step("wrap");
        end
        idle(); commit_ack = 1; step("wrap_drain"); idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                set_alloc(1'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0)
                set_cdb(int'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 65535)),
                        1'($urandom_range(0, 1)));
            commit_ack = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            rd_tag0 = TW'($urandom_range(0, DEPTH - 1));
            rd_tag1 = TW'($urandom_range(0, DEPTH - 1));
            step("rand");
        end

        // Asynchronous reset mid-stream with 5 busy entries
        idle(); flush = 1; step("flush4"); idle();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b0, 16'h0, 1'b0, 1'b0);
            step("areset_fill");
        end
        idle(); rd_tag0 = 3'd1; set_cdb(1, 16'h7777, 1'b0);
        #2;
        rst = 1;
        #1;
        chk("areset.empty", empty, 1'b1);
        chk("areset.full", full, 1'b0);
        chk("areset.alloc_tag", alloc_tag, 0);
        chk("areset.commit_valid", commit_valid, 1'b0);
        chk("areset.rd_ready0", rd_ready0, 1'b0);
        chk("areset.rd_value0", rd_value0, 0);
        rob.delete(); ntag = 0;
        idle();
        @(posedge clk);
        #1;
        rst = 0;
        step("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
